rgb_to_bayer_mosaic: RTL

RGB_TO_BAYER_MOSAIC -- requirements
Module: rgb_to_bayer_mosaic

---
 rtl/bayer_pkg.sv | 38 +++
 rtl/pixel_skid_buffer.sv | 62 ++++++
 rtl/rgb_to_bayer_mosaic.sv | 102 ++++++++++
 3 files changed

// File: rtl/bayer_pkg.sv
// Shared types for the RGB-to-Bayer mosaic path: pixel-type codes, CFA
// pattern codes and the packed raw-pixel record carried through the skid buffer.
package bayer_pkg;

  typedef enum logic [1:0] {
    BLUE           = 2'd0,
    GREEN_BLUE_ROW = 2'd1,
    GREEN_RED_ROW  = 2'd2,
    RED            = 2'd3
  } pixel_type_e;

  localparam logic [1:0] BGGR = 2'd0;
  localparam logic [1:0] GBRG = 2'd1;
  localparam logic [1:0] GRBG = 2'd2;
  localparam logic [1:0] RGGB = 2'd3;

  typedef struct packed {
    logic [7:0]  raw;
    pixel_type_e ptype;
    logic        sof;
    logic        eol;
  } raw_pixel_t;

  localparam int PIXEL_W = $bits(raw_pixel_t);

  // Pick the single colour channel a Bayer site keeps; a pure select.
  function automatic logic [7:0] bayer_sample(input logic [23:0] rgb,
                                              input pixel_type_e ptype);
    logic [7:0] s;
    case (ptype)
      RED:     s = rgb[23:16];
      BLUE:    s = rgb[7:0];
      default: s = rgb[15:8];
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pixel_skid_buffer.sv
// Two-entry ready/valid skid buffer with a registered upstream ready, so no
// combinational path exists from the downstream ready to the upstream ready.
module pixel_skid_buffer #(
  parameter int W = 12
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         ready_q;
  logic         push;
  logic         pop;

  assign push    = valid_i && ready_q;
  assign pop     = (count_q != 2'd0) && ready_i;
  assign valid_o = (count_q != 2'd0);
  assign ready_o = ready_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // A push only lands in a free slot, so the head entry never changes while stalled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
      ready_q <= (count_d != 2'd2);
    end
  end

endmodule

// File: rtl/rgb_to_bayer_mosaic.sv
// Converts an RGB pixel stream into a Bayer-mosaiced raw stream, tracking the
// frame position and flagging start-of-frame sync violations.
module rgb_to_bayer_mosaic
  import bayer_pkg::*;
#(
  parameter int         WIDTH   = 640,
  parameter int         HEIGHT  = 480,
  parameter logic [1:0] PATTERN = BGGR
) (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_rgb,
  input  logic        in_sof,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_raw,
  output logic [1:0]  out_pixel_type,
  output logic        out_sof,
  output logic        out_eol,
  output logic        frame_error
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic [XW-1:0] x_q, x_d, px;
  logic [YW-1:0] y_q, y_d, py;
  logic          at_origin;
  logic          sync_err;
  logic          push;
  logic          frame_error_q;
  pixel_type_e   ptype;
  raw_pixel_t    in_pix;
  raw_pixel_t    out_pix;
  logic [PIXEL_W-1:0] out_bits;

  assign push = in_valid && in_ready;

  // An accepted sof forces (0,0); otherwise the counters place the pixel.
  always_comb begin
    at_origin = (x_q == '0) && (y_q == '0);
    px        = in_sof ? '0 : x_q;
    py        = in_sof ? '0 : y_q;
    sync_err  = in_sof ? !at_origin : at_origin;
    ptype     = pixel_type_e'(PATTERN ^ {py[0], px[0]});
    in_pix.raw   = bayer_sample(in_rgb, ptype);
    in_pix.ptype = ptype;
    in_pix.sof   = (px == '0) && (py == '0);
    in_pix.eol   = (px == X_LAST);
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (push) begin
      if (px == X_LAST) begin
        x_d = '0;
        y_d = (py == Y_LAST) ? '0 : py + YW'(1);
      end else begin
        x_d = px + XW'(1);
        y_d = py;
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= '0;
      y_q           <= '0;
      frame_error_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      frame_error_q <= push && sync_err;
    end
  end

  pixel_skid_buffer #(
    .W (PIXEL_W)
  ) u_skid (
    .clk_i   (clk_pixel),
    .rst_n_i (reset_n),
    .valid_i (in_valid),
    .ready_o (in_ready),
    .data_i  (in_pix),
    .valid_o (out_valid),
    .ready_i (out_ready),
    .data_o  (out_bits)
  );

  assign out_pix        = raw_pixel_t'(out_bits);
  assign out_raw        = out_pix.raw;
  assign out_pixel_type = out_pix.ptype;
  assign out_sof        = out_pix.sof;
  assign out_eol        = out_pix.eol;
  assign frame_error    = frame_error_q;

endmodule
